// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: widths, ALU control codes,
// code classification helpers and the request payload type.
package alu_share_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 6;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] ALU_ADD     = 6'b000000;
    localparam logic [CTRL_W-1:0] ALU_SLT     = 6'b000001;
    localparam logic [CTRL_W-1:0] ALU_SLTU    = 6'b000010;
    localparam logic [CTRL_W-1:0] ALU_AND     = 6'b000011;
    localparam logic [CTRL_W-1:0] ALU_OR      = 6'b000100;
    localparam logic [CTRL_W-1:0] ALU_XOR     = 6'b000101;
    localparam logic [CTRL_W-1:0] ALU_SLL     = 6'b000110;
    localparam logic [CTRL_W-1:0] ALU_SRL     = 6'b000111;
    localparam logic [CTRL_W-1:0] ALU_SUB     = 6'b001000;
    localparam logic [CTRL_W-1:0] ALU_SRA     = 6'b001001;
    localparam logic [CTRL_W-1:0] ALU_ADDI    = 6'b111111;
    localparam logic [CTRL_W-1:0] ALU_SLTI    = 6'b111110;
    localparam logic [CTRL_W-1:0] ALU_SLTIU   = 6'b111101;
    localparam logic [CTRL_W-1:0] ALU_ANDI    = 6'b111100;
    localparam logic [CTRL_W-1:0] ALU_ORI     = 6'b111011;
    localparam logic [CTRL_W-1:0] ALU_XORI    = 6'b111010;
    localparam logic [CTRL_W-1:0] ALU_SLLI    = 6'b111000;
    localparam logic [CTRL_W-1:0] ALU_SRA_ALT = 6'b101010;

    typedef struct packed {
        logic [CTRL_W-1:0] control;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   imm;
        logic [TAG_W-1:0]  tag;
    } req_t;

    function automatic logic is_legal(input logic [CTRL_W-1:0] code);
        case (code)
            ALU_ADD, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
            ALU_SRL, ALU_SUB, ALU_SRA, ALU_ADDI, ALU_SLTI, ALU_SLTIU,
            ALU_ANDI, ALU_ORI, ALU_XORI, ALU_SLLI, ALU_SRA_ALT: is_legal = 1'b1;
            default:                                          is_legal = 1'b0;
        endcase
    endfunction

    // Register-operand shifts: only rs2[4:0] is a meaningful shift amount.
    function automatic logic is_shift(input logic [CTRL_W-1:0] code);
        is_shift = (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, response and ALU-side signals of the shared ALU arbiter.
interface alu_share_arb_if;
    import alu_share_pkg::*;

    logic              r0_valid, r0_ready;
    logic [CTRL_W-1:0] r0_control;
    logic [XLEN-1:0]   r0_rs1, r0_rs2, r0_imm;
    logic [TAG_W-1:0]  r0_tag;

    logic              r1_valid, r1_ready;
    logic [CTRL_W-1:0] r1_control;
    logic [XLEN-1:0]   r1_rs1, r1_rs2, r1_imm;
    logic [TAG_W-1:0]  r1_tag;

    logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic [XLEN-1:0]   rsp_result;

    logic [CTRL_W-1:0] alu_control;
    logic [XLEN-1:0]   alu_rs1, alu_rs2, alu_imm, alu_result;

    modport slave (
        input  r0_valid, r0_control, r0_rs1, r0_rs2, r0_imm, r0_tag,
        input  r1_valid, r1_control, r1_rs1, r1_rs2, r1_imm, r1_tag,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_err, rsp_tag, rsp_result,
        input  rsp_ready,
        output alu_control, alu_rs1, alu_rs2, alu_imm,
        input  alu_result
    );

    modport master (
        output r0_valid, r0_control, r0_rs1, r0_rs2, r0_imm, r0_tag,
        output r1_valid, r1_control, r1_rs1, r1_rs2, r1_imm, r1_tag,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_err, rsp_tag, rsp_result,
        output rsp_ready,
        input  alu_control, alu_rs1, alu_rs2, alu_imm,
        output alu_result
    );

endinterface

// File: rtl/alu_share_arb_rr.sv
// Two-way round-robin picker; remembers the last accepted grant.
module alu_share_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_c
);

    logic last_q, last_d;

    // On conflict the port that did not win last time is favoured.
    always_comb begin : pick
        grant_c = valid_i;
        last_d  = last_q;
        if (valid_i == 2'b11) begin
            grant_c = last_q ? 2'b01 : 2'b10;
        end
        if (en_i && (valid_i != 2'b00)) begin
            last_d = grant_c[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : last_reg
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto a shared combinational ALU through a
// registered operand stage (A) and a buffered response stage (B).
module alu_share_arb
    import alu_share_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus
);

    logic [1:0] grant_c;
    logic       b_free, a_free, en, accept;
    req_t       req_in;

    logic       a_valid_q, a_valid_d;
    logic       a_id_q, a_id_d;
    logic       a_legal_q, a_legal_d;
    req_t       a_req_q, a_req_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [XLEN-1:0]  rsp_result_q, rsp_result_d;

    alu_share_rr u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i ({bus.r1_valid, bus.r0_valid}),
        .en_i    (en),
        .grant_c (grant_c)
    );

    // Readiness is gated by rst_n so no request is acknowledged during reset.
    always_comb begin : advance
        b_free = !rsp_valid_q || bus.rsp_ready;
        a_free = !a_valid_q || b_free;
        en     = a_free && rst_n;
        accept = en && (grant_c != 2'b00);
    end

    assign bus.r0_ready = en & grant_c[0];
    assign bus.r1_ready = en & grant_c[1];

    // Shift amounts are masked at capture so stage A drives the ALU directly.
    always_comb begin : capture_mux
        req_in.control = grant_c[1] ? bus.r1_control : bus.r0_control;
        req_in.rs1     = grant_c[1] ? bus.r1_rs1     : bus.r0_rs1;
        req_in.rs2     = grant_c[1] ? bus.r1_rs2     : bus.r0_rs2;
        req_in.imm     = grant_c[1] ? bus.r1_imm     : bus.r0_imm;
        req_in.tag     = grant_c[1] ? bus.r1_tag     : bus.r0_tag;
        if (is_shift(req_in.control)) begin
            req_in.rs2 = XLEN'(req_in.rs2[SHAMT_W-1:0]);
        end
        if (req_in.control == ALU_SLLI) begin
            req_in.imm = XLEN'(req_in.imm[SHAMT_W-1:0]);
        end
    end

    always_comb begin : stage_next
        a_valid_d    = a_valid_q;
        a_id_d       = a_id_q;
        a_legal_d    = a_legal_q;
        a_req_d      = a_req_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;

        if (accept) begin
            a_valid_d = 1'b1;
            a_id_d    = grant_c[1];
            a_legal_d = is_legal(req_in.control);
            a_req_d   = req_in;
        end else if (b_free) begin
            a_valid_d = 1'b0;
            a_id_d    = 1'b0;
            a_legal_d = 1'b0;
            a_req_d   = '0;
        end

        // Illegal codes never expose whatever the ALU produced.
        if (a_valid_q && b_free) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = a_id_q;
            rsp_err_d    = !a_legal_q;
            rsp_tag_d    = a_req_q.tag;
            rsp_result_d = a_legal_q ? bus.alu_result : '0;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
            rsp_id_d     = 1'b0;
            rsp_err_d    = 1'b0;
            rsp_tag_d    = '0;
            rsp_result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
        if (!rst_n) begin
            a_valid_q    <= 1'b0;
            a_id_q       <= 1'b0;
            a_legal_q    <= 1'b0;
            a_req_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_id_q       <= a_id_d;
            a_legal_q    <= a_legal_d;
            a_req_q      <= a_req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign bus.alu_control = a_req_q.control;
    assign bus.alu_rs1     = a_req_q.rs1;
    assign bus.alu_rs2     = a_req_q.rs2;
    assign bus.alu_imm     = a_req_q.imm;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU and an in-order
// response scoreboard.
module tb_alu_share_arb;

    typedef struct {
        logic [5:0]  c;
        logic [31:0] rs1, rs2, imm;
        logic [3:0]  tag;
    } op_t;

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arb_if bus ();
    alu_share_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_rsp = 0;
    op_t  pend0[$];
    op_t  pend1[$];
    rsp_t sb[$];
    int   grant_log[$];
    int   rsp_id_log[$];
    int   rsp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] i);
        case (c)
            6'b000000: alu_fn = a + b;
            6'b000001: alu_fn = {31'b0, $signed(a) < $signed(b)};
            6'b000010: alu_fn = {31'b0, a < b};
            6'b000011: alu_fn = a & b;
            6'b000100: alu_fn = a | b;
            6'b000101: alu_fn = a ^ b;
            6'b000110: alu_fn = a << b;
            6'b000111: alu_fn = a >> b;
            6'b001000: alu_fn = a - b;
            6'b001001: alu_fn = 32'($signed(a) >>> b);
            6'b111111: alu_fn = a + i;
            6'b111110: alu_fn = {31'b0, $signed(a) < $signed(i)};
            6'b111101: alu_fn = {31'b0, a < i};
            6'b111100: alu_fn = a & i;
            6'b111011: alu_fn = a | i;
            6'b111010: alu_fn = a ^ i;
            6'b111000: alu_fn = a << i;
            6'b101010: alu_fn = 32'($signed(a) >>> i);
            default:   alu_fn = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_control, bus.alu_rs1, bus.alu_rs2, bus.alu_imm);

    function automatic logic tb_legal(input logic [5:0] c);
        case (c)
            6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
            6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b111111, 6'b111110,
            6'b111101, 6'b111100, 6'b111011, 6'b111010, 6'b111000, 6'b101010:
                tb_legal = 1'b1;
            default: tb_legal = 1'b0;
        endcase
    endfunction

    function automatic rsp_t expect_rsp(input op_t o, input logic id);
        rsp_t r;
        logic [31:0] b, i;
        b = (o.c == 6'b000110 || o.c == 6'b000111 || o.c == 6'b001001) ? {27'b0, o.rs2[4:0]} : o.rs2;
        i = (o.c == 6'b111000) ? {27'b0, o.imm[4:0]} : o.imm;
        r.id  = id;
        r.tag = o.tag;
        r.err = !tb_legal(o.c);
        r.res = r.err ? 32'h0 : alu_fn(o.c, o.rs1, b, i);
        return r;
    endfunction

    function automatic op_t mk(input logic [5:0] c, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [3:0] tag);
        op_t o;
        o.c = c; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.tag = tag;
        return o;
    endfunction

    function automatic op_t rand_op(input int t);
        logic [5:0] c;
        case ($urandom_range(0, 5))
            0: c = 6'b000000;
            1: c = 6'b001000;
            2: c = 6'b000110;
            3: c = 6'b111000;
            4: c = 6'b000101;
            default: c = 6'b010101;
        endcase
        return mk(c, $urandom, $urandom, $urandom, 4'(t));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor samples just before the commit edge; driver updates just after it.
    initial begin : drv_mon
        bit a0, a1;
        rsp_t e;
        forever begin
            @(negedge clk);
            a0 = 1'b0;
            a1 = 1'b0;
            if (rst_n) begin
                a0 = bus.r0_valid && bus.r0_ready;
                a1 = bus.r1_valid && bus.r1_ready;
                if (a0) begin sb.push_back(expect_rsp(pend0[0], 1'b0)); grant_log.push_back(0); n_acc++; end
                if (a1) begin sb.push_back(expect_rsp(pend1[0], 1'b1)); grant_log.push_back(1); n_acc++; end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_rsp", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
                        chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
                        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    rsp_id_log.push_back(int'(bus.rsp_id));
                    rsp_cyc.push_back(cyc);
                    n_rsp++;
                end
            end
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (a0 && pend0.size() > 0) pend0.delete(0);
                if (a1 && pend1.size() > 0) pend1.delete(0);
            end
            bus.r0_valid = (pend0.size() > 0);
            if (pend0.size() > 0) begin
                bus.r0_control = pend0[0].c; bus.r0_rs1 = pend0[0].rs1; bus.r0_rs2 = pend0[0].rs2;
                bus.r0_imm = pend0[0].imm; bus.r0_tag = pend0[0].tag;
            end
            bus.r1_valid = (pend1.size() > 0);
            if (pend1.size() > 0) begin
                bus.r1_control = pend1[0].c; bus.r1_rs1 = pend1[0].rs1; bus.r1_rs2 = pend1[0].rs2;
                bus.r1_imm = pend1[0].imm; bus.r1_tag = pend1[0].tag;
            end
        end
    end

    task automatic single_op(input bit port, input op_t o, input logic [31:0] e_rs2,
                             input logic [31:0] e_imm, input logic [31:0] e_res, input logic e_err);
        bit got;
        got = 1'b0;
        if (port) pend1.push_back(o); else pend0.push_back(o);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = port ? (bus.r1_valid && bus.r1_ready) : (bus.r0_valid && bus.r0_ready);
        end
        chk("so_accept", 64'(got), 64'(1));
        @(negedge clk);
        chk("so_rsp_valid_n1", 64'(bus.rsp_valid), 64'(0));
        chk("so_alu_control", 64'(bus.alu_control), 64'(o.c));
        chk("so_alu_rs2", 64'(bus.alu_rs2), 64'(e_rs2));
        chk("so_alu_imm", 64'(bus.alu_imm), 64'(e_imm));
        @(negedge clk);
        chk("so_rsp_valid_n2", 64'(bus.rsp_valid), 64'(1));
        chk("so_result", 64'(bus.rsp_result), 64'(e_res));
        chk("so_err", 64'(bus.rsp_err), 64'(e_err));
        chk("so_id", 64'(bus.rsp_id), 64'(port));
        chk("so_tag", 64'(bus.rsp_tag), 64'(o.tag));
        tick();
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((sb.size() > 0 || pend0.size() > 0 || pend1.size() > 0 || bus.rsp_valid) && t < 300) begin
            tick();
            t++;
        end
        chk({tag, "_drained"}, 64'(t < 300), 64'(1));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        pend0.delete(); pend1.delete(); sb.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] snap_res, snap_rs1;
        logic [3:0]  snap_tag;
        int base, t;

        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b1;
        bus.r0_control = '0; bus.r0_rs1 = '0; bus.r0_rs2 = '0; bus.r0_imm = '0; bus.r0_tag = '0;
        bus.r1_control = '0; bus.r1_rs1 = '0; bus.r1_rs2 = '0; bus.r1_imm = '0; bus.r1_tag = '0;
        rst_n = 1'b0;
        pend0.push_back(mk(6'b000000, 32'd1, 32'd1, 32'd0, 4'd0));
        tick(); tick(); tick();
        chk("rst_r0_valid_presented", 64'(bus.r0_valid), 64'(1));
        chk("rst_r0_ready", 64'(bus.r0_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
        chk("rst_alu_rs1", 64'(bus.alu_rs1), 64'(0));
        chk("rst_alu_control", 64'(bus.alu_control), 64'(0));
        pend0.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Contention from reset: port 0 first, then alternate.
        grant_log.delete(); rsp_id_log.delete(); rsp_cyc.delete();
        pend0.push_back(mk(6'b000000, 32'd10, 32'd1, 32'd0, 4'd1));
        pend0.push_back(mk(6'b001000, 32'd10, 32'd3, 32'd0, 4'd2));
        pend1.push_back(mk(6'b000011, 32'hF0F0, 32'hFF00, 32'd0, 4'd3));
        pend1.push_back(mk(6'b111111, 32'd100, 32'd0, 32'd23, 4'd4));
        drain("cont");
        chk("cont_ngrants", 64'(grant_log.size()), 64'(4));
        chk("cont_nrsp", 64'(rsp_cyc.size()), 64'(4));
        if (grant_log.size() == 4 && rsp_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cont_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));
                chk($sformatf("cont_rsp_id%0d", k), 64'(rsp_id_log[k]), 64'(k % 2));
            end
            chk("cont_rsp_span", 64'(rsp_cyc[3] - rsp_cyc[0]), 64'(3));
        end

        // Directed single ops: latency, shift masking, illegal code.
        single_op(1'b0, mk(6'b000000, 32'd5, 32'd7, 32'd0, 4'd3), 32'd7, 32'd0, 32'd12, 1'b0);
        single_op(1'b0, mk(6'b000110, 32'd1, 32'h23, 32'd0, 4'd5), 32'd3, 32'd0, 32'd8, 1'b0);
        single_op(1'b1, mk(6'b111000, 32'd1, 32'd0, 32'h41, 4'd6), 32'd0, 32'd1, 32'd2, 1'b0);
        single_op(1'b1, mk(6'b010101, 32'd9, 32'd9, 32'd9, 4'd7), 32'd9, 32'd9, 32'd0, 1'b1);
        drain("directed");

        // Backpressure with both ports streaming.
        bus.rsp_ready = 1'b0;
        base = n_rsp;
        for (int k = 0; k < 4; k++) begin
            pend0.push_back(rand_op(k));
            pend1.push_back(rand_op(k + 8));
        end
        repeat (5) tick();
        @(negedge clk);
        snap_res = bus.rsp_result; snap_tag = bus.rsp_tag; snap_rs1 = bus.alu_rs1;
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_result_stable", 64'(bus.rsp_result), 64'(snap_res));
            chk("bp_tag_stable", 64'(bus.rsp_tag), 64'(snap_tag));
            chk("bp_alu_stable", 64'(bus.alu_rs1), 64'(snap_rs1));
            chk("bp_ready_low", 64'({bus.r1_ready, bus.r0_ready}), 64'(0));
            chk("bp_inflight", 64'(n_acc - n_rsp <= 2), 64'(1));
        end
        tick();
        bus.rsp_ready = 1'b1;
        drain("bp");
        chk("bp_all_returned", 64'(n_rsp - base), 64'(8));

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 6; k++) begin
            pend0.push_back(rand_op(k));
            pend1.push_back(rand_op(k + 6));
        end
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mrst_rsp_result", 64'(bus.rsp_result), 64'(0));
        chk("mrst_rsp_tag", 64'(bus.rsp_tag), 64'(0));
        chk("mrst_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("mrst_rsp_err", 64'(bus.rsp_err), 64'(0));
        chk("mrst_alu", 64'({bus.alu_control, bus.alu_rs1, bus.alu_rs2, bus.alu_imm} == '0), 64'(1));
        chk("mrst_ready", 64'({bus.r1_ready, bus.r0_ready}), 64'(0));
        pend0.delete(); pend1.delete(); sb.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        grant_log.delete();
        pend0.push_back(mk(6'b000101, 32'hAAAA, 32'h5555, 32'd0, 4'd9));
        pend1.push_back(mk(6'b000000, 32'd2, 32'd2, 32'd0, 4'd10));
        t = 0;
        while (grant_log.size() < 2 && t < 50) begin tick(); t++; end
        chk("mrst_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() >= 1) chk("mrst_first_grant", 64'(grant_log[0]), 64'(0));
        drain("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
